load_store_unit: RTL
====================

# load_store_unit

Memory-access stage sitting directly upstream of `data_memory`. It accepts one load or store per request handshake and converts byte, halfword and word accesses into word-only `MemRead`/`MemWrite` cycles on the data memory. Sub-word stores are done as read-modify-write. Load data is aligned and sign/zero-extended, and every request returns one completion pulse to writeback.

## Interface
Parameters:
- `DATA_MEM_WIDTH`, default 3: word-index bits used by the downstream memory; higher address bits alias.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle, request accepted on `req_valid && req_ready` at the rising edge.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified for sub-word stores.
- `req_rd`  in  5  destination tag, returned unchanged.
- `mem_address`  out  32  word address = {2'b00, addr[31:2]}.
- `mem_write_data`  out  32  word to write.
- `mem_MemWrite`  out  1  memory write strobe.
- `mem_MemRead`  out  1  memory read strobe.
- `mem_read_data`  in  32  memory registered read data, valid the cycle after a `mem_MemRead` edge.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  load result; 0 for stores and faults.
- `resp_rd`  out  5  captured `req_rd`.
- `resp_fault`  out  1  misaligned or illegal-size request; qualified by `resp_valid`.

## Operation
- Request fields are captured into internal registers on accept. Inputs are ignored while `req_ready`=0.
- FSM states are IDLE, RD, RWAIT, WR and RESP. Outputs are decoded from the registered state:
  - `req_ready` = IDLE
  - `mem_MemRead` = RD
  - `mem_MemWrite` = WR
  - `resp_valid` = RESP
- Transitions from IDLE on accept:
  - Fault: the request goes to RESP. A fault is `req_size`=11, halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Word store: the request goes to WR.
  - Load or sub-word store: the request goes to RD.
- Other transitions:
  - RD always goes to RWAIT.
  - RWAIT goes to RESP for a load, or to WR for a sub-word store.
  - WR always goes to RESP.
  - RESP always goes to IDLE.
- Faulting requests produce no memory strobe. They return `resp_fault`=1 and `resp_data`=0.
- Load formatting is registered on the RWAIT→RESP edge:
  - Byte: lane = addr[1:0], data = `mem_read_data`[8·lane+7:8·lane].
  - Halfword: data = `mem_read_data`[16·addr[1]+15:16·addr[1]].
  - Word: data passes through unchanged.
  - Extension is by `req_unsigned`.
- Store merge is registered on the RWAIT→WR edge. The selected byte or halfword lane of `mem_read_data` is replaced with the low bits of the captured `wdata`; the other lanes are preserved.
- For a word store, `mem_write_data` is the captured `wdata`.
- `mem_address` is held from accept until return to IDLE. Addresses beyond 2^DATA_MEM_WIDTH words alias and do not fault.

## Timing
Edge E0 is the accept edge.
- Word store:
  - `mem_MemWrite` is high in the cycle after E0; memory writes at E1.
  - `resp_valid` is high in the cycle after E1.
  - `req_ready` returns after E2.
- Load:
  - `mem_MemRead` is high in the cycle after E0.
  - Data is sampled at E2.
  - `resp_valid` is high in the cycle after E2, a latency of 3 edges.
- Sub-word store:
  - Read as for a load; the merge is sampled at E2.
  - `mem_MemWrite` is high in the cycle after E2.
  - `resp_valid` is high in the cycle after E3.
- Fault: `resp_valid` is high in the cycle after E0.
- Issue rate is at most one request per (latency + 1) cycles. There is no overlap and no accept during RESP.
- `resp_*` values are stable throughout the RESP cycle and hold their last value otherwise.
- Reset values:
  - State is IDLE, so `req_ready`=1 during and after reset.
  - `mem_MemRead`, `mem_MemWrite`, `resp_valid` and `resp_fault` are 0.
  - `mem_address`, `mem_write_data`, `resp_data` and `resp_rd` are 0.
- Reset mid-operation aborts the request immediately, with no response.
  - A WR cycle cut by reset before its edge performs no write.
  - Memory contents are not cleared.

## Test plan
1. Word store 0xDEADBEEF to 0x8, then word load 0x8 with rd=5 -> mem word 2 written; `resp_valid` 3 edges after the load accept, with `resp_data`=0xDEADBEEF and `resp_rd`=5.
2. Byte store 0x12 to 0x9 over 0xDEADBEEF -> word 2 = 0xDEAD12EF; `mem_MemRead` one cycle, then `mem_MemWrite` one cycle; resp 4 edges after accept.
3. Byte loads from 0xB on word 0x80AD12EF -> signed gives 0xFFFFFF80, unsigned gives 0x00000080. Halfword signed load from 0xA gives 0xFFFF80AD.
4. Halfword load at 0x3 and word store at 0x6 -> `resp_fault`=1 and `resp_data`=0 the cycle after accept; no memory strobe; memory unchanged.
5. `req_valid` held high continuously across 4 mixed requests -> each is accepted only in IDLE; responses arrive in order with correct tags; there is never more than one outstanding request.
6. Assert `reset` during the WR cycle of a byte store -> no write occurs; all outputs go to reset values asynchronously; `req_ready`=1; the next load returns the old word.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: turns byte/halfword/word loads and stores into word-only
// read/write cycles, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int DATA_MEM_WIDTH = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_fault
);

  // Word aliasing above 2^DATA_MEM_WIDTH is the memory's business; only sanity-check the width.
  if (DATA_MEM_WIDTH < 1 || DATA_MEM_WIDTH > 30) begin : g_bad_width
    $error("DATA_MEM_WIDTH out of range");
  end

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] RWAIT = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]  state;
  logic        wr_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wdata_q;
  logic [4:0]  rd_q;
  logic        fault_in;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt, store_merge;

  assign req_ready    = (state == IDLE);
  assign mem_MemRead  = (state == RD);
  assign mem_MemWrite = (state == WR);
  assign resp_valid   = (state == RESP);

  always_comb begin
    fault_in = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    ld_byte = mem_read_data[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (size_q)
      2'b00:   load_fmt = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_fmt = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_fmt = mem_read_data;
    endcase
  end

  // Only sub-word stores reach the merge; word stores bypass the read.
  always_comb begin
    store_merge = mem_read_data;
    if (size_q == 2'b00) store_merge[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 store_merge[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      wdata_q        <= '0;
      rd_q           <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_data      <= '0;
      resp_rd        <= '0;
      resp_fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q        <= req_write;
          uns_q       <= req_unsigned;
          size_q      <= req_size;
          off_q       <= req_addr[1:0];
          wdata_q     <= req_wdata[15:0];
          rd_q        <= req_rd;
          mem_address <= {2'b00, req_addr[31:2]};
          if (fault_in) begin
            resp_data  <= '0;
            resp_rd    <= req_rd;
            resp_fault <= 1'b1;
            state      <= RESP;
          end else if (req_write && req_size == 2'b10) begin
            mem_write_data <= req_wdata;
            state          <= WR;
          end else begin
            state <= RD;
          end
        end
        RD: state <= RWAIT;
        RWAIT: if (wr_q) begin
          mem_write_data <= store_merge;
          state          <= WR;
        end else begin
          resp_data  <= load_fmt;
          resp_rd    <= rd_q;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        WR: begin
          resp_data  <= '0;
          resp_rd    <= rd_q;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
